// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter with line conditioning and ACK/timeout handling.
module ps2_tx_filt #(
  parameter int FILTER = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic f
);
  logic [1:0] s_q;
  logic       f_q, f_d;
  logic [7:0] c_q, c_d;
  always_comb begin
    f_d = f_q;
    c_d = 8'd0;
    if (s_q[1] != f_q) begin
      c_d = c_q + 8'd1;
      if (c_q == 8'(FILTER - 1)) begin
        f_d = s_q[1];
        c_d = 8'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 2'b11;
      f_q <= 1'b1;
      c_q <= 8'd0;
    end else begin
      s_q <= {s_q[0], raw};
      f_q <= f_d;
      c_q <= c_d;
    end
  end
  assign f = f_q;
endmodule

module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 200,
  parameter int FILTER         = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_mask,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        par_q, par_d, data_oe_q, data_oe_d, clk_prev_q;
  logic        done_q, done_d, err_q, err_d, to_q, to_d;
  logic        clk_f, data_f, fall, timeout;
  ps2_tx_filt #(.FILTER(FILTER)) u_clk_filt (.clk(clk), .rst(rst), .raw(ps2_clk_in), .f(clk_f));
  ps2_tx_filt #(.FILTER(FILTER)) u_data_filt (.clk(clk), .rst(rst), .raw(ps2_data_in), .f(data_f));
  assign fall    = clk_prev_q & ~clk_f;
  assign timeout = (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) &&
                   cnt_q == 32'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    par_d     = par_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          state_d = INHIBIT;
          cnt_d   = 32'd0;
          byte_d  = tx_data;
          par_d   = ~^tx_data;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          state_d   = REQ;
          cnt_d     = 32'd0;
          data_oe_d = 1'b1;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(REQ_CYCLES - 1)) begin
          state_d = SEND;
          cnt_d   = 32'd0;
          bit_d   = 4'd0;
        end
      end
      SEND: begin
        cnt_d = cnt_q + 32'd1;
        if (fall) begin
          bit_d     = bit_q + 4'd1;
          data_oe_d = bit_q < 4'd8 ? ~byte_q[bit_q[2:0]] : bit_q == 4'd8 ? ~par_q : 1'b0;
          state_d   = bit_q == 4'd10 ? ACK : SEND;
        end
      end
      ACK: begin
        cnt_d     = cnt_q + 32'd1;
        data_oe_d = 1'b0;
        err_d     = data_f;
        state_d   = data_f ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d = cnt_q + 32'd1;
        if (clk_f && data_f) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timeout overrides whatever the edge logic decided this cycle.
    if (timeout) begin
      state_d   = IDLE;
      data_oe_d = 1'b0;
      to_d      = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      bit_q      <= 4'd0;
      byte_q     <= 8'd0;
      par_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      clk_prev_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      data_oe_q  <= data_oe_d;
      clk_prev_q <= clk_f;
      done_q     <= done_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end
  assign tx_ready    = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign rx_mask     = busy;
  assign ps2_clk_oe  = state_q == INHIBIT || state_q == REQ;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_ack_err  = err_q;
  assign tx_timeout  = to_q;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: PS/2 device model plus scoreboard of expected frames for ps2_tx.
module tb_ps2_tx;
  localparam int INH = 100, RQ = 10, FLT = 4, TO = 5000;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_mask, tx_done, tx_ack_err, tx_timeout;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       clk_line, data_line;
  int         passed = 0, total = 0;
  int         n_clk_oe = 0, n_done = 0, n_err = 0, n_to = 0;
  logic [3:0] pulse_snap = 4'd0;
  logic [1:0] post_snap = 2'd0;
  logic       pend = 1'b0;
  logic [9:0] sb[$];

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .FILTER(FLT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .rx_mask(rx_mask), .tx_done(tx_done),
    .tx_ack_err(tx_ack_err), .tx_timeout(tx_timeout)
  );

  // Pulse counters and line/status snapshots at (and one cycle after) each terminal pulse.
  always @(negedge clk) begin
    if (ps2_clk_oe) n_clk_oe <= n_clk_oe + 1;
    if (tx_done) n_done <= n_done + 1;
    if (tx_ack_err) n_err <= n_err + 1;
    if (tx_timeout) n_to <= n_to + 1;
    if (tx_done | tx_ack_err | tx_timeout) pulse_snap <= {ps2_clk_oe, ps2_data_oe, busy, tx_ready};
    if (pend) post_snap <= {busy, tx_ready};
    pend <= tx_done | tx_ack_err | tx_timeout;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    sb.push_back({1'b1, ~^b, b});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: waits for request-to-send, then clocks 11 bits, sampling data before each rising edge.
  task automatic dev_frame(input bit ack, input bit glitch, input int stop_after,
                           output logic [10:0] bits, output bit ok);
    ok   = 1'b0;
    bits = 11'd0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
    end
    if (!ok) return;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (glitch && c == 10) dev_clk_low = 1'b1;
        if (glitch && c == 12) dev_clk_low = 1'b0;
      end
      dev_clk_low = 1'b1;
      if (k == stop_after) return;
      repeat (40) @(negedge clk);
      bits[k-1]   = data_line;
      dev_clk_low = 1'b0;
    end
    repeat (10) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_term(input int base);
    for (int i = 0; i < 2000 && (n_done + n_err + n_to) == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ps2_clk_oe, ps2_data_oe, busy, rx_mask, tx_done, tx_ack_err, tx_timeout, tx_ready} !== 8'b00000001)
      $display("FAIL reset_state: got %b want 00000001",
               {ps2_clk_oe, ps2_data_oe, busy, rx_mask, tx_done, tx_ack_err, tx_timeout, tx_ready});
    else passed++;
  endtask

  task automatic test_send_ed(input string tag);
    int c0, d0, e0, t0;
    logic [10:0] bits;
    logic [9:0]  exp;
    bit          ok;
    c0 = n_clk_oe; d0 = n_done; e0 = n_err; t0 = n_to;
    start_tx(8'hED);
    total++;
    if ({ps2_clk_oe, busy, rx_mask, tx_ready} !== 4'b1110)
      $display("FAIL %s accept_latency: got %b want 1110", tag, {ps2_clk_oe, busy, rx_mask, tx_ready});
    else passed++;
    dev_frame(1'b1, 1'b0, 0, bits, ok);
    total++;
    if (!ok) $display("FAIL %s request_seen: got 0 want 1", tag); else passed++;
    wait_term(d0 + e0 + t0);
    exp = sb.pop_front();
    total++;
    if (bits[9:0] !== exp) $display("FAIL %s frame_bits: got %b want %b", tag, bits[9:0], exp);
    else passed++;
    total++;
    if (n_clk_oe - c0 !== INH + RQ)
      $display("FAIL %s clk_low_cycles: got %0d want %0d", tag, n_clk_oe - c0, INH + RQ);
    else passed++;
    total++;
    if (n_done - d0 !== 1 || n_err !== e0 || n_to !== t0)
      $display("FAIL %s pulses: got done=%0d err=%0d to=%0d want 1/0/0", tag, n_done - d0, n_err - e0, n_to - t0);
    else passed++;
    total++;
    if (pulse_snap !== 4'b0001 || post_snap !== 2'b01)
      $display("FAIL %s done_status: got %b/%b want 0001/01", tag, pulse_snap, post_snap);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [10:0] bits;
    logic [9:0]  exp;
    bit          ok;
    d0 = n_done + n_err + n_to;
    @(negedge clk);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    sb.push_back({1'b1, ~^tx_data, tx_data});
    @(negedge clk);
    tx_data = 8'h00;
    dev_frame(1'b1, 1'b0, 0, bits, ok);
    for (int i = 0; i < 500 && n_done + n_err + n_to == d0; i++) @(negedge clk);
    sb.push_back({1'b1, ~^tx_data, tx_data});
    @(negedge clk);
    tx_valid = 1'b0;
    exp = sb.pop_front();
    total++;
    if (!ok || bits[9:0] !== exp) $display("FAIL b2b_first_frame: got %b want %b", bits[9:0], exp);
    else passed++;
    total++;
    if (bits[8] !== 1'b0) $display("FAIL b2b_parity_01: got %b want 0", bits[8]); else passed++;
    total++;
    if (post_snap !== 2'b10) $display("FAIL b2b_accept_next_cycle: got %b want 10", post_snap);
    else passed++;
    d0 = n_done + n_err + n_to;
    dev_frame(1'b1, 1'b0, 0, bits, ok);
    wait_term(d0);
    exp = sb.pop_front();
    total++;
    if (!ok || bits[9:0] !== exp) $display("FAIL b2b_second_frame: got %b want %b", bits[9:0], exp);
    else passed++;
    total++;
    if (bits[8] !== 1'b1) $display("FAIL b2b_parity_00: got %b want 1", bits[8]); else passed++;
  endtask

  task automatic test_no_ack();
    int d0, e0, t0;
    logic [10:0] bits;
    logic [9:0]  exp;
    bit          ok;
    d0 = n_done; e0 = n_err; t0 = n_to;
    start_tx(8'hFF);
    dev_frame(1'b0, 1'b0, 0, bits, ok);
    wait_term(d0 + e0 + t0);
    exp = sb.pop_front();
    total++;
    if (!ok || bits[9:0] !== exp) $display("FAIL noack_frame: got %b want %b", bits[9:0], exp);
    else passed++;
    total++;
    if (n_err - e0 !== 1 || n_done !== d0 || n_to !== t0)
      $display("FAIL noack_pulses: got err=%0d done=%0d to=%0d want 1/0/0", n_err - e0, n_done - d0, n_to - t0);
    else passed++;
    total++;
    if (pulse_snap !== 4'b0001 || post_snap !== 2'b01)
      $display("FAIL noack_status: got %b/%b want 0001/01", pulse_snap, post_snap);
    else passed++;
  endtask

  task automatic test_timeout();
    int  d0, e0, t0, cnt;
    bit  found;
    d0 = n_done; e0 = n_err; t0 = n_to;
    start_tx(8'h5A);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) found = 1'b1;
    end
    cnt = 0;
    if (found)
      for (int i = 0; i < TO + 1000; i++) begin
        @(negedge clk);
        cnt++;
        if (tx_timeout) break;
      end
    repeat (3) @(negedge clk);
    void'(sb.pop_front());
    total++;
    if (cnt !== TO) $display("FAIL timeout_latency: got %0d want %0d", cnt, TO); else passed++;
    total++;
    if (n_to - t0 !== 1 || n_done !== d0 || n_err !== e0)
      $display("FAIL timeout_pulses: got to=%0d done=%0d err=%0d want 1/0/0", n_to - t0, n_done - d0, n_err - e0);
    else passed++;
    total++;
    if (pulse_snap !== 4'b0001 || post_snap !== 2'b01)
      $display("FAIL timeout_status: got %b/%b want 0001/01", pulse_snap, post_snap);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int b0;
    logic [10:0] bits;
    bit          ok;
    b0 = n_done + n_err + n_to;
    start_tx(8'hED);
    dev_frame(1'b1, 1'b0, 5, bits, ok);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000)
      $display("FAIL midreset_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    else passed++;
    rst         = 1'b0;
    dev_clk_low = 1'b0;
    void'(sb.pop_front());
    repeat (50) @(negedge clk);
    total++;
    if (!ok || n_done + n_err + n_to !== b0)
      $display("FAIL midreset_no_pulse: got %0d want 0", n_done + n_err + n_to - b0);
    else passed++;
    test_send_ed("after_reset");
  endtask

  task automatic test_glitch();
    int b0;
    logic [10:0] bits;
    logic [9:0]  exp;
    bit          ok;
    b0 = n_done;
    start_tx(8'hA5);
    dev_frame(1'b1, 1'b1, 0, bits, ok);
    wait_term(b0 + n_err + n_to);
    exp = sb.pop_front();
    total++;
    if (!ok || bits[9:0] !== exp) $display("FAIL glitch_frame: got %b want %b", bits[9:0], exp);
    else passed++;
    total++;
    if (n_done - b0 !== 1) $display("FAIL glitch_done: got %0d want 1", n_done - b0); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_ed("basic_ed");
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_mid_reset();
    test_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
